// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the serial adder controller.
// Holds the FSM encoding, the bits-per-step constant and the counter sizing.
package serial_add_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int STEP_BITS = 2;

  // Step counter width; never narrower than one bit, even when there is a single step.
  function automatic int cnt_width(input int width);
    int steps;
    steps = width / STEP_BITS;
    return (steps <= 2) ? 1 : $clog2(steps);
  endfunction

endpackage

// File: rtl/two_adder.sv
// Two-bit ripple slice built from two full-adder cells; purely combinational.
module two_adder (
  input  logic a0,
  input  logic a1,
  input  logic b0,
  input  logic b1,
  input  logic cin,
  output logic s0,
  output logic s1,
  output logic cout
);

  logic c1;

  assign s0   = a0 ^ b0 ^ cin;
  assign c1   = (a0 & b0) | (cin & (a0 ^ b0));
  assign s1   = a1 ^ b1 ^ c1;
  assign cout = (a1 & b1) | (c1 & (a1 ^ b1));

endmodule

// File: rtl/serial_add_seq.sv
// Multi-cycle WIDTH-bit adder: one two-bit slice reused for WIDTH/2 cycles,
// LSB pair first, with valid/ready handshakes on both sides.
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int STEPS = WIDTH / STEP_BITS;
  localparam int CW    = cnt_width(WIDTH);

  if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_width_chk
    $fatal(1, "serial_add_seq: WIDTH must be even and >= 2");
  end

  state_t          state, state_nx;
  logic [CW-1:0]   count;
  logic            carry;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nx;
  logic            s0, s1, sc;
  logic            accept, last;

  two_adder u_slice (
    .a0   (a_sh[0]),
    .a1   (a_sh[1]),
    .b0   (b_sh[0]),
    .b1   (b_sh[1]),
    .cin  (carry),
    .s0   (s0),
    .s1   (s1),
    .cout (sc)
  );

  // New pair enters at the top; after STEPS shifts the LSB pair sits at bit 0.
  assign sum_nx = (sum_sh >> STEP_BITS) | (WIDTH'({s1, s0}) << (WIDTH - STEP_BITS));

  assign accept    = in_valid & in_ready;
  assign last      = (count == CW'(STEPS - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)    state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // sum/cout are only written on the final step, so they stay stable in DONE
  // and keep the previous result through IDLE and the next RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      carry  <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      carry  <= cin;
      count  <= '0;
      sum_sh <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> STEP_BITS;
      b_sh   <= b_sh >> STEP_BITS;
      sum_sh <= sum_nx;
      carry  <= sc;
      count  <= count + 1'b1;
      if (last) begin
        sum  <= sum_nx;
        cout <= sc;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench: vector table through a scoreboard, plus hand-written
// backpressure, reset-abort and WIDTH=2 sequences.
module tb_serial_add_seq;

  localparam int STEPS = 4;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;

  typedef struct packed {
    logic [7:0] s;
    logic       co;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
  logic [7:0] a, b, sum;

  logic       w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_cin, w_cout, w_busy;
  logic [1:0] w_a, w_b, w_sum;

  int   nvec = 0;
  int   nerr = 0;
  exp_t sbq[$];
  exp_t e;
  vec_t vt[8];

  always #5 clk = ~clk;

  serial_add_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  serial_add_seq #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .a(w_a), .b(w_b), .cin(w_cin), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .sum(w_sum), .cout(w_cout), .busy(w_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: pop one expected result per output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_out", 32'(sbq.size()), 32'd1);
      end else begin
        e = sbq.pop_front();
        chk("sb_sum", 32'(sum), 32'(e.s));
        chk("sb_cout", 32'(cout), 32'(e.co));
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                      input logic [7:0] es, input logic eco);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    @(posedge clk);
    sbq.push_back({es, eco});
    #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
  endtask

  task automatic lat_chk();
    for (int k = 1; k <= STEPS; k++) begin
      @(posedge clk); #1;
      chk("latency_out_valid", 32'(out_valid), 32'(k == STEPS));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vt[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vt[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vt[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
    vt[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vt[6] = '{8'hAB, 8'hCD, 1'b1, 8'h79, 1'b1};
    vt[7] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    w_in_valid = 1'b0; w_out_ready = 1'b1; w_a = '0; w_b = '0; w_cin = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    foreach (vt[i]) begin
      send(vt[i].a, vt[i].b, vt[i].cin, vt[i].s, vt[i].co);
      chk("run_in_ready", 32'(in_ready), 32'd0);
      chk("run_busy", 32'(busy), 32'd1);
      lat_chk();
      @(posedge clk); #1;
      chk("ret_in_ready", 32'(in_ready), 32'd1);
      chk("ret_out_valid", 32'(out_valid), 32'd0);
    end

    // Backpressure with in_valid held high and new operands waiting.
    out_ready = 1'b0;
    send(8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
    in_valid = 1'b1; a = 8'hAA; b = 8'h00; cin = 1'b0;
    repeat (STEPS - 1) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_sum", 32'(sum), 32'h30);
      chk("bp_cout", 32'(cout), 32'd0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_in_ready", 32'(in_ready), 32'd1);
    sbq.push_back({8'hAA, 1'b0});
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_busy", 32'(busy), 32'd1);
    lat_chk();
    @(posedge clk); #1;

    // Reset in the second RUN cycle.
    send(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("rst_run_out_valid", 32'(out_valid), 32'd0);
    chk("rst_run_busy", 32'(busy), 32'd0);
    sbq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(8'h01, 8'h02, 1'b0, 8'h03, 1'b0);
    lat_chk();
    @(posedge clk); #1;

    // Reset while DONE is stalled.
    out_ready = 1'b0;
    send(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    lat_chk();
    rst = 1'b1; #1;
    chk("rst_done_out_valid", 32'(out_valid), 32'd0);
    chk("rst_done_busy", 32'(busy), 32'd0);
    sbq.delete();
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    send(8'h01, 8'h02, 1'b0, 8'h03, 1'b0);
    lat_chk();
    @(posedge clk); #1;

    // WIDTH=2 build: one RUN cycle.
    chk("w2_in_ready", 32'(w_in_ready), 32'd1);
    w_a = 2'd3; w_b = 2'd3; w_cin = 1'b1; w_in_valid = 1'b1;
    @(posedge clk); #1;
    w_in_valid = 1'b0; w_a = 2'd0; w_b = 2'd0; w_cin = 1'b0;
    chk("w2_run_out_valid", 32'(w_out_valid), 32'd0);
    chk("w2_run_busy", 32'(w_busy), 32'd1);
    @(posedge clk); #1;
    chk("w2_out_valid", 32'(w_out_valid), 32'd1);
    chk("w2_sum", 32'(w_sum), 32'd3);
    chk("w2_cout", 32'(w_cout), 32'd1);
    @(posedge clk); #1;
    chk("w2_ret_in_ready", 32'(w_in_ready), 32'd1);

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
